fsm_0101_nov: RTL and testbench

//   Serial pattern detector for the bit sequence 0-1-0-1, non-overlapping.

---
 rtl/fsm_0101_nov_pkg.sv | 14 +
 rtl/fsm_0101_nov_if.sv | 9 +
 rtl/fsm_0101_nov.sv | 45 ++++
 tb/tb_fsm_0101_nov.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/fsm_0101_nov_pkg.sv
// Shared definitions for the 0-1-0-1 serial pattern detector.
package fsm0101_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S0 = 2'b00;
    localparam state_t S1 = 2'b01;
    localparam state_t S2 = 2'b10;
    localparam state_t S3 = 2'b11;

    // Pattern written oldest bit first (MSB is the first bit on the wire).
    localparam logic [3:0] PATTERN = 4'b0101;

endpackage

// File: rtl/fsm_0101_nov_if.sv
// Serial bit stream into the detector, match flag and state observation out.
interface fsm_0101_nov_if;
    logic       In;
    logic       Out;
    logic [1:0] State;

    modport master (output In, input Out, input State);
    modport slave  (input In, output Out, output State);
endinterface

// File: rtl/fsm_0101_nov.sv
// Non-overlapping 0-1-0-1 detector, one bit per clock, Mealy match flag.
//
//   state | meaning
//   ------+------------------------------
//   S0    | idle, no useful prefix
//   S1    | seen "0"
//   S2    | seen "01"
//   S3    | seen "010"; a 1 now completes the match
module fsm_0101_nov
    import fsm0101_pkg::*;
(
    input  logic           Clk,
    input  logic           rst,
    fsm_0101_nov_if.slave  bus
);

    state_t state_q;
    state_t state_d;

    // State register; reset discards any partial prefix immediately.
    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state. A completed match returns to S0 so its bits are never reused;
    // a 0 after "010" is kept as a fresh leading 0.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S0:      state_d = bus.In ? S0 : S1;
            S1:      state_d = bus.In ? S2 : S1;
            S2:      state_d = bus.In ? S0 : S3;
            S3:      state_d = bus.In ? S0 : S1;
            default: state_d = S0;
        endcase
    end

    assign bus.State = state_q;
    assign bus.Out   = (state_q == S3) && bus.In;

endmodule

// File: tb/tb_fsm_0101_nov.sv
// Directed bench for the 0-1-0-1 detector with a history-based reference model.
module tb_fsm_0101_nov;

    logic Clk;
    logic rst;
    fsm_0101_nov_if bus ();

    fsm_0101_nov dut (
        .Clk (Clk),
        .rst (rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #10 Clk = ~Clk;

    int  n_cmp   = 0;
    int  n_fail  = 0;
    int  pulses  = 0;
    bit  cmp_en  = 1'b0;

    // Pattern oldest-first.
    bit pat [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    // Bits received since the last reset or the last completed match.
    bit hist [$];

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // True when the history followed by bit b ends with the full pattern.
    function automatic bit ends_in_match(input bit q [$], input bit b);
        bit t [$];
        t = q;
        t.push_back(b);
        if (t.size() < 4) return 1'b0;
        for (int i = 0; i < 4; i++)
            if (t[t.size() - 4 + i] != pat[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Length of the longest tail of the history that is a start of the pattern.
    function automatic int prefix_len(input bit q [$]);
        for (int k = 3; k >= 1; k--) begin
            if (q.size() >= k) begin
                bit ok;
                ok = 1'b1;
                for (int i = 0; i < k; i++)
                    if (q[q.size() - k + i] != pat[i]) ok = 1'b0;
                if (ok) return k;
            end
        end
        return 0;
    endfunction

    // Reference model advances on each accepted bit.
    always @(posedge Clk or negedge rst) begin
        if (!rst) begin
            hist.delete();
        end else if (ends_in_match(hist, bus.In)) begin
            hist.delete();
        end else begin
            hist.push_back(bus.In);
            while (hist.size() > 3) void'(hist.pop_front());
        end
    end

    // Per-cycle compare, mid-cycle after the new bit has settled.
    always @(negedge Clk) begin
        #2;
        if (cmp_en) begin
            logic exp_out;
            exp_out = rst && ends_in_match(hist, bus.In);
            chk("state_model", bus.State, 2'(prefix_len(hist)));
            chk("out_model", {1'b0, bus.Out}, {1'b0, exp_out});
            if (bus.Out === 1'b1) pulses++;
        end
    end

    task automatic drive_bit(input bit b);
        @(negedge Clk);
        bus.In = b;
        @(posedge Clk);
        #1;
    endtask

    task automatic reset_pulse();
        #3 rst = 1'b0;
        #1;
        chk("async_reset_state", bus.State, 2'b00);
        chk("async_reset_out", {1'b0, bus.Out}, 2'b00);
        #2 rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] exp2 [6];
        bit         in2  [6];
        exp2 = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b11, 2'b00};
        in2  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        // 1: reset, release, then a mid-cycle reset pulse from S1
        rst    = 1'b0;
        bus.In = 1'b1;
        #5;
        chk("reset_state", bus.State, 2'b00);
        chk("reset_out", {1'b0, bus.Out}, 2'b00);
        @(negedge Clk);
        rst    = 1'b1;
        cmp_en = 1'b1;
        drive_bit(1'b0);
        chk("after_first_zero", bus.State, 2'b01);
        reset_pulse();

        // 2: basic match
        for (int i = 0; i < 6; i++) begin
            drive_bit(in2[i]);
            chk($sformatf("basic_state_%0d", i), bus.State, exp2[i]);
        end
        @(negedge Clk); #3;
        chk("basic_pulses", 2'(pulses), 2'd1);

        // 3: non-overlap continuation
        foreach (in2[i]) ;
        drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0);
        drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b0);
        @(negedge Clk); #3;
        chk("nonoverlap_pulses", 2'(pulses), 2'd2);
        chk("nonoverlap_state", bus.State, 2'b01);

        // 4: prefix recovery, match only on the 7th bit
        drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0);
        drive_bit(1'b0);
        chk("recovery_s1", bus.State, 2'b01);
        drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
        chk("recovery_state", bus.State, 2'b00);
        @(negedge Clk); #3;
        chk("recovery_pulses", 2'(pulses), 2'd3);

        // 5: dead ends
        drive_bit(1'b1); drive_bit(1'b1); drive_bit(1'b1);
        chk("dead_ones", bus.State, 2'b00);
        drive_bit(1'b0); drive_bit(1'b1);
        chk("dead_01", bus.State, 2'b10);
        drive_bit(1'b1);
        chk("dead_011", bus.State, 2'b00);

        // 6: async reset after "010", then a 1 must not match
        drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0);
        chk("pre_reset_s3", bus.State, 2'b11);
        reset_pulse();
        drive_bit(1'b1);
        chk("post_reset_state", bus.State, 2'b00);
        @(negedge Clk); #3;
        chk("final_pulses", 2'(pulses), 2'd3);

        @(negedge Clk);
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
